lc3b_wb_stage: RTL and testbench

Writeback stage directly downstream of the LC-3b ALU. Buffers ALU results in a 2-entry FIFO, arbitrates the single register-file write port against the load-return path (loads win), and maintains the NZP condition-code register. Provides valid/ready backpressure to the execute stage when the write port is busy with loads.

---
 rtl/lc3b_wb_stage.sv | 114 +++++++++++
 tb/tb_lc3b_wb_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lc3b_wb_stage.sv
// LC-3b writeback stage: 2-entry ALU result FIFO, load-priority RF write port, NZP register.
// Optional LC3B_WB_PEND_MASK_EN drives pend_mask from buffered destinations; otherwise it is 0.
module lc3b_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_AW-1:0] alu_dr,
  input  logic              alu_setcc,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] ld_dr,
  input  logic              ld_setcc,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              cc_n,
  output logic              cc_z,
  output logic              cc_p,
  output logic [7:0]        pend_mask
);

  logic [DATA_W-1:0] mem_result [2];
  logic [REG_AW-1:0] mem_dr     [2];
  logic              mem_setcc  [2];
  logic              head, tail;
  logic [1:0]        count;
  logic [2:0]        nzp_q;
  logic              push, pop;

  assign alu_ready = (count < 2'd2) && !flush;
  assign push      = alu_valid && alu_ready;
  assign pop       = !ld_valid && (count != 2'd0) && !flush;

  assign cc_n = nzp_q[2];
  assign cc_z = nzp_q[1];
  assign cc_p = nzp_q[0];

  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] d);
    if (d[DATA_W-1])       return 3'b100;
    else if (d == '0)      return 3'b010;
    else                   return 3'b001;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[tail] <= alu_result;
      mem_dr[tail]     <= alu_dr;
      mem_setcc[tail]  <= alu_setcc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      nzp_q    <= 3'b010;
    end else begin
      if (ld_valid) begin
        rf_we    <= 1'b1;
        rf_waddr <= ld_dr;
        rf_wdata <= ld_data;
        if (ld_setcc) nzp_q <= nzp_of(ld_data);
      end else if (pop) begin
        rf_we    <= 1'b1;
        rf_waddr <= mem_dr[head];
        rf_wdata <= mem_result[head];
        if (mem_setcc[head]) nzp_q <= nzp_of(mem_result[head]);
        head     <= ~head;
      end else begin
        rf_we    <= 1'b0;
      end

      if (push) tail <= ~tail;

      // flush also realigns the pointers so the next push lands in slot 0
      if (flush) begin
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
      end else if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

`ifdef LC3B_WB_PEND_MASK_EN
  logic [1:0] slot_valid;

  always_comb begin
    slot_valid        = 2'b00;
    slot_valid[head]  = (count != 2'd0);
    slot_valid[~head] = (count == 2'd2);
    pend_mask         = 8'h00;
    for (int i = 0; i < 2; i++) begin
      if (slot_valid[i]) pend_mask = pend_mask | (8'h01 << mem_dr[i]);
    end
  end
`else
  assign pend_mask = 8'h00;
`endif

endmodule

// File: tb/tb_lc3b_wb_stage.sv
// Self-checking bench for lc3b_wb_stage: directed scenarios plus random traffic vs a queue model.
module tb_lc3b_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [15:0] alu_result = '0;
  logic [2:0]  alu_dr = '0;
  logic        alu_setcc = 1'b0;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = '0;
  logic [2:0]  ld_dr = '0;
  logic        ld_setcc = 1'b0;
  logic        flush = 1'b0;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        cc_n, cc_z, cc_p;
  logic [7:0]  pend_mask;

  lc3b_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_result(alu_result),
    .alu_dr(alu_dr), .alu_setcc(alu_setcc),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_dr(ld_dr), .ld_setcc(ld_setcc),
    .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cc_n(cc_n), .cc_z(cc_z), .cc_p(cc_p), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  dr;
    logic        setcc;
  } entry_t;

  entry_t      q[$];
  logic        exp_we;
  logic [2:0]  exp_waddr;
  logic [15:0] exp_wdata;
  logic [2:0]  exp_cc;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_mask();
    logic [7:0] m = 8'h00;
`ifdef LC3B_WB_PEND_MASK_EN
    foreach (q[i]) m[q[i].dr] = 1'b1;
`endif
    return m;
  endfunction

  function automatic void model_commit(input logic [15:0] d, input logic [2:0] dr, input logic sc);
    exp_we    = 1'b1;
    exp_waddr = dr;
    exp_wdata = d;
    if (sc) exp_cc = d[15] ? 3'b100 : (d == 16'h0000) ? 3'b010 : 3'b001;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_we",    32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_cc",    32'({cc_n, cc_z, cc_p}), 32'b010);
    chk("rst_pend",  32'(pend_mask), 32'd0);
    q.delete();
    exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0; exp_cc = 3'b010;
    alu_valid = 1'b0; ld_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
  endtask

  // one clock: drive at negedge, check combinational outputs, advance model, check registered outputs
  task automatic cyc(input logic av, input logic [15:0] ar, input logic [2:0] adr, input logic asc,
                     input logic lv, input logic [15:0] ld, input logic [2:0] ldr, input logic lsc,
                     input logic fl);
    logic   exp_ready;
    entry_t e;
    alu_valid = av; alu_result = ar; alu_dr = adr; alu_setcc = asc;
    ld_valid = lv; ld_data = ld; ld_dr = ldr; ld_setcc = lsc; flush = fl;
    #1;
    exp_ready = (q.size() < 2) && !fl;
    chk("alu_ready", 32'(alu_ready), 32'(exp_ready));
    chk("pend_mask", 32'(pend_mask), 32'(model_mask()));
    if (lv) model_commit(ld, ldr, lsc);
    else if (q.size() > 0 && !fl) begin
      e = q.pop_front();
      model_commit(e.data, e.dr, e.setcc);
    end else exp_we = 1'b0;
    if (fl) q.delete();
    else if (av && exp_ready) q.push_back('{data: ar, dr: adr, setcc: asc});
    @(posedge clk);
    #1;
    chk("rf_we", 32'(rf_we), 32'(exp_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(exp_waddr));
    chk("rf_wdata", 32'(rf_wdata), 32'(exp_wdata));
    chk("nzp", 32'({cc_n, cc_z, cc_p}), 32'(exp_cc));
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
  endtask

  logic [7:0] pend_exp;

  initial begin
    @(negedge clk);
    do_reset();

    // single ALU result, negative
    cyc(1'b1, 16'h8000, 3'd3, 1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    idle();
    chk("single_we", 32'(rf_we), 32'd1);
    chk("single_addr", 32'(rf_waddr), 32'd3);
    chk("single_data", 32'(rf_wdata), 32'h8000);
    chk("single_cc", 32'({cc_n, cc_z, cc_p}), 32'b100);
    idle();

    // load priority over two buffered results
    cyc(1'b1, 16'h0005, 3'd1, 1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0000, 3'd2, 1'b1, 1'b1, 16'h0007, 3'd4, 1'b1, 1'b0);
    chk("prio_ld_addr", 32'(rf_waddr), 32'd4);
    idle();
    chk("prio_r1_addr", 32'(rf_waddr), 32'd1);
    idle();
    chk("prio_r2_addr", 32'(rf_waddr), 32'd2);
    chk("prio_cc", 32'({cc_n, cc_z, cc_p}), 32'b010);
    idle();

    // backpressure under continuous loads
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 16'h1100 + 16'(i), 3'(i), 1'b0, 1'b1, 16'h0020 + 16'(i), 3'd6, 1'b0, 1'b0);
    chk("bp_ready", 32'(alu_ready), 32'd0);
    idle();
    chk("bp_first", 32'(rf_wdata), 32'h1100);
    idle();
    chk("bp_second", 32'(rf_wdata), 32'h1101);
    idle();

    // pend_mask with R2 and R5 buffered
    cyc(1'b1, 16'h0002, 3'd2, 1'b0, 1'b1, 16'h0, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0005, 3'd5, 1'b0, 1'b1, 16'h0, 3'd0, 1'b0, 1'b0);
`ifdef LC3B_WB_PEND_MASK_EN
    pend_exp = 8'h24;
`else
    pend_exp = 8'h00;
`endif
    chk("pend_r2r5", 32'(pend_mask), 32'(pend_exp));

    // flush with full FIFO and concurrent load
    cyc(1'b1, 16'h0AAA, 3'd0, 1'b1, 1'b1, 16'hFFFF, 3'd7, 1'b1, 1'b1);
    chk("flush_addr", 32'(rf_waddr), 32'd7);
    chk("flush_cc", 32'({cc_n, cc_z, cc_p}), 32'b100);
    chk("flush_pend", 32'(pend_mask), 32'd0);
    idle();
    chk("flush_nowrite", 32'(rf_we), 32'd0);

    // reset mid-stream with two buffered entries
    cyc(1'b1, 16'h0123, 3'd1, 1'b1, 1'b1, 16'h0001, 3'd0, 1'b1, 1'b0);
    cyc(1'b1, 16'h0456, 3'd2, 1'b1, 1'b1, 16'h0002, 3'd0, 1'b1, 1'b0);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom), 1'($urandom),
          1'($urandom_range(0, 2) == 0), 16'($urandom), 3'($urandom), 1'($urandom),
          1'($urandom_range(0, 15) == 0));
      if (i == 250) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
